// File: rtl/pc_redirect_unit.sv
// Fetch-side PC owner: sequential fetch, EX-stage redirects, stall hold, and a
// one-entry buffer for a redirect that arrives while instruction memory is busy.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             npc_op,
  input  logic [31:0]      pc_jump,
  input  logic             stall,
  input  logic             imem_ready,
  output logic [31:0]      pc,
  output logic [31:0]      pc4,
  output logic             imem_req,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        run;
  logic [31:0] tgt;
  logic        have_src;
  logic [31:0] src;
  logic        capture;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    state_d      = RUN;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    cnt_d        = cnt_q;

    run      = (state_q == RUN);
    tgt      = {pc_jump[31:2], 2'b00};
    // A buffered redirect always wins; npc_op alongside it is ignored.
    have_src = pend_valid_q | npc_op;
    src      = pend_valid_q ? pend_pc_q : tgt;
    capture  = run & npc_op & ~pend_valid_q;
    misalign_d = capture & (|pc_jump[1:0]);

    if (run) begin
      if (imem_ready) begin
        if (have_src) begin
          pc_d         = src;
          pend_valid_d = 1'b0;
          cnt_d        = sat_inc(cnt_q);
        end else if (!stall) begin
          pc_d = pc_q + 32'd4;
        end
      end else if (capture) begin
        pend_valid_d = 1'b1;
        pend_pc_d    = tgt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0;
      misalign_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      misalign_q   <= misalign_d;
      cnt_q        <= cnt_d;
    end
  end

  assign pc           = pc_q;
  assign pc4          = pc_q + 32'd4;
  assign imem_req     = (state_q == RUN);
  assign flush_if_id  = (npc_op | pend_valid_q) & (state_q == RUN);
  assign flush_id_ex  = flush_if_id;
  assign misalign_err = misalign_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit with an in-bench behavioural model and
// literal pins on the key points of each scenario.
module tb_pc_redirect_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int unsigned CW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          npc_op = 1'b0;
  logic [31:0]   pc_jump = 32'h0;
  logic          stall = 1'b0;
  logic          imem_ready = 1'b1;
  logic [31:0]   pc, pc4;
  logic          imem_req, flush_if_id, flush_id_ex, misalign_err;
  logic [CW-1:0] redirect_cnt;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  pc_redirect_unit #(.RESET_PC(RPC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .npc_op(npc_op), .pc_jump(pc_jump), .stall(stall),
    .imem_ready(imem_ready), .pc(pc), .pc4(pc4), .imem_req(imem_req),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .misalign_err(misalign_err), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: architectural state plus rules applied per edge.
  bit          m_run = 1'b0;
  logic [31:0] m_pc = RPC;
  bit          m_pend = 1'b0;
  logic [31:0] m_pend_pc = 32'h0;
  bit          m_mis = 1'b0;
  int          m_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 1'b0; m_pc = RPC; m_pend = 1'b0; m_pend_pc = 32'h0; m_mis = 1'b0; m_cnt = 0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_mis = 1'b0;
    end else begin
      if (npc_op && m_pend) begin
        errors++;
        $display("FAIL illegal_npc_while_pending at %0t", $time);
      end
      m_mis = npc_op && !m_pend && (pc_jump % 4 != 0);
      if (imem_ready) begin
        if (m_pend || npc_op) begin
          m_pc = m_pend ? m_pend_pc : (pc_jump / 4) * 4;
          m_pend = 1'b0;
          if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
        end else if (!stall) begin
          m_pc = m_pc + 32'd4;
        end
      end else if (npc_op && !m_pend) begin
        m_pend = 1'b1;
        m_pend_pc = (pc_jump / 4) * 4;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("pc", pc, m_pc);
      chk("pc4", pc4, m_pc + 32'd4);
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_run});
      chk("flush_if_id", {31'b0, flush_if_id}, {31'b0, m_run && (npc_op || m_pend)});
      chk("flush_id_ex", {31'b0, flush_id_ex}, {31'b0, m_run && (npc_op || m_pend)});
      chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
      chk("redirect_cnt", {28'b0, redirect_cnt}, m_cnt);
    end
  end

  task automatic set_in(input logic n, input logic [31:0] j, input logic s, input logic r);
    #1;
    npc_op = n; pc_jump = j; stall = s; imem_ready = r;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    tick(); tick();
    started = 1'b1;
    tick();
    chk("pin_rst_pc", pc, 32'h100);
    chk("pin_rst_req", {31'b0, imem_req}, 32'h0);
    chk("pin_rst_pc4", pc4, 32'h104);

    // Boot: one cycle of BOOT after release, then sequential fetch.
    #1 rst = 1'b0;
    #1 chk("pin_boot_req", {31'b0, imem_req}, 32'h0);
    chk("pin_boot_pc", pc, 32'h100);
    tick(); chk("pin_run_pc0", pc, 32'h100); chk("pin_run_req", {31'b0, imem_req}, 32'h1);
    set_in(0, 0, 0, 1); tick(); chk("pin_run_pc1", pc, 32'h104);
    tick(); chk("pin_run_pc2", pc, 32'h108);

    // Taken redirect.
    set_in(1, 32'h200, 0, 1);
    #1 chk("pin_redir_flush", {31'b0, flush_if_id}, 32'h1);
    tick(); chk("pin_redir_pc", pc, 32'h200); chk("pin_redir_cnt", {28'b0, redirect_cnt}, 32'h1);

    // Redirect beats stall, then stall holds.
    set_in(1, 32'h300, 1, 1); tick(); chk("pin_rvs_pc", pc, 32'h300);
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 1, 1); tick(); chk("pin_stall_pc", pc, 32'h300);
    end
    set_in(0, 0, 0, 1); tick(); chk("pin_unstall_pc", pc, 32'h304);

    // Busy memory buffers the redirect.
    set_in(1, 32'h400, 0, 0);
    #1 chk("pin_busy_flush0", {31'b0, flush_id_ex}, 32'h1);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, i == 1, 0); tick();
      chk("pin_busy_flush", {31'b0, flush_if_id}, 32'h1);
      chk("pin_busy_pc", pc, 32'h304);
    end
    set_in(0, 0, 0, 1); tick();
    chk("pin_busy_pc_out", pc, 32'h400);
    chk("pin_busy_flush_drop", {31'b0, flush_if_id}, 32'h0);

    // Misaligned target, applied and buffered.
    set_in(1, 32'h503, 0, 1); tick();
    chk("pin_mis_pc", pc, 32'h500); chk("pin_mis_err", {31'b0, misalign_err}, 32'h1);
    set_in(0, 0, 0, 1); tick(); chk("pin_mis_clear", {31'b0, misalign_err}, 32'h0);
    set_in(1, 32'h601, 0, 0); tick(); chk("pin_mis_buf", {31'b0, misalign_err}, 32'h1);
    set_in(0, 0, 0, 1); tick(); chk("pin_mis_buf_pc", pc, 32'h600);

    // Wrap-around of the PC.
    set_in(1, 32'hFFFF_FFFC, 0, 1); tick();
    chk("pin_wrap_pc4", pc4, 32'h0);
    set_in(0, 0, 0, 1); tick();
    chk("pin_wrap_pc", pc, 32'h0); chk("pin_wrap_pc4b", pc4, 32'h4);

    // Counter saturation.
    for (int i = 0; i < 12; i++) begin
      set_in(1, 32'h1000 + i * 16, 0, 1); tick();
    end
    chk("pin_cnt_sat", {28'b0, redirect_cnt}, 32'hF);
    set_in(1, 32'h2000, 0, 1); tick();
    chk("pin_cnt_hold", {28'b0, redirect_cnt}, 32'hF);

    // Reset with a redirect pending.
    set_in(1, 32'h700, 0, 0); tick();
    set_in(0, 0, 0, 0);
    #1 chk("pin_pend_flush", {31'b0, flush_if_id}, 32'h1);
    rst = 1'b1;
    #1 chk("pin_arst_pc", pc, 32'h100);
    chk("pin_arst_flush", {31'b0, flush_if_id}, 32'h0);
    chk("pin_arst_cnt", {28'b0, redirect_cnt}, 32'h0);
    tick();
    set_in(0, 0, 0, 1); rst = 1'b0;
    tick(); chk("pin_after_rst_pc", pc, 32'h100);
    tick(); chk("pin_after_rst_pc1", pc, 32'h104);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
